// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue blocks.
// The key/value pair type and the counter width are defined here so every block sizes them the same way.
package pq_pkg;

    localparam int KEY_WIDTH   = 8;
    localparam int VAL_WIDTH   = 8;
    localparam int PQ_CAPACITY = 16;
    localparam int PQ_CNT_W    = $clog2(PQ_CAPACITY + 1);

    localparam logic [KEY_WIDTH-1:0] KEY0 = '0;
    localparam logic [VAL_WIDTH-1:0] VAL0 = '0;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    localparam kv_t KV_RESET = '{key: KEY0, val: VAL0};

    // Item counters stop at the queue capacity instead of wrapping.
    function automatic logic [PQ_CNT_W-1:0] sat_inc(input logic [PQ_CNT_W-1:0] c);
        return (c >= PQ_CNT_W'(PQ_CAPACITY)) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/kv_fifo.sv
// Small FIFO of key/value pairs that sits between the drain engine and the downstream consumer.
// The head entry is always visible. A push into a full buffer is dropped, so the caller must wait until the buffer is no longer full.
module kv_fifo
    import pq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  kv_t  din,
    output kv_t  head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    kv_t           mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= KV_RESET;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pq_drain.sv
// Drains items from a priority queue into an output buffer.
// It either drains a fixed number of items or drains until the queue reports empty.
module pq_drain
    import pq_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PQ_CNT_W-1:0] n_req,
    input  logic                pq_empty,
    input  logic                pq_busy,
    input  kv_t                 pq_kvo,
    output logic                pq_deq,
    output logic                out_valid,
    input  logic                out_ready,
    output kv_t                 out_kv,
    output logic                busy,
    output logic                done,
    output logic                underflow,
    output logic [PQ_CNT_W-1:0] n_done
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SETTLE,
        FLUSH
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PQ_CNT_W-1:0] remaining;
    logic                drain_all;
    logic                want_more;
    logic                deq_req;
    logic                set_uf;
    logic                buf_full;
    logic                buf_empty;

    assign want_more = drain_all || (remaining != '0);
    assign busy      = (state != IDLE);
    assign out_valid = !buf_empty;
    // A strobe raised in the same cycle as reset must never reach the queue.
    assign pq_deq    = deq_req && !rst;

    always_comb begin
        state_nxt = state;
        deq_req   = 1'b0;
        set_uf    = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (want_more && !pq_busy && !pq_empty && !buf_full) begin
                    deq_req   = 1'b1;
                    state_nxt = SETTLE;
                end else if (!drain_all && (remaining == '0)) begin
                    state_nxt = FLUSH;
                end else if (!pq_busy && pq_empty) begin
                    state_nxt = FLUSH;
                    set_uf    = !drain_all;
                end
            end
            SETTLE: begin
                state_nxt = CHECK;
            end
            FLUSH: begin
                if (buf_empty) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The drain mode is latched at start so that later changes on n_req are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            drain_all <= 1'b0;
            n_done    <= '0;
            underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start) begin
                remaining <= n_req;
                drain_all <= (n_req == '0);
                n_done    <= '0;
                underflow <= 1'b0;
            end
            if (deq_req) begin
                n_done <= sat_inc(n_done);
                if (remaining != '0) begin
                    remaining <= remaining - 1'b1;
                end
            end
            if (set_uf) begin
                underflow <= 1'b1;
            end
        end
    end

    kv_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (deq_req),
        .pop  (out_valid && out_ready),
        .din  (pq_kvo),
        .head (out_kv),
        .full (buf_full),
        .empty(buf_empty)
    );

endmodule

// File: doc/pq_drain.md
PQ_DRAIN -- requirements
Module: pq_drain

Interface
REQ-001 Parameter: BUF_DEPTH, default 2; entries in the output buffer; legal values are 2 or 4.
REQ-002 Port: clk  in  1  rising-edge clock; single clock domain.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle request to begin a drain; sampled only in IDLE.
REQ-005 Port: n_req  in  PQ_CNT_W  number of items to drain; 0 means drain until the queue is empty.
REQ-006 Port: pq_empty  in  1  empty flag from the priority queue.
REQ-007 Port: pq_busy  in  1  busy flag from the priority queue.
REQ-008 Port: pq_kvo  in  kv_t  current minimum key-value pair from the queue.
REQ-009 Port: pq_deq  out  1  dequeue strobe to the queue, one cycle wide.
REQ-010 Port: out_valid  out  1  out_kv holds a valid item.
REQ-011 Port: out_ready  in  1  downstream accepts the item.
REQ-012 Port: out_kv  out  kv_t  head of the output buffer.
REQ-013 Port: busy  out  1  high in every state except IDLE.
REQ-014 Port: done  out  1  one-cycle pulse when a drain completes.
REQ-015 Port: underflow  out  1  the queue emptied before n_req items (n_req>0); held until the next start.
REQ-016 Port: n_done  out  PQ_CNT_W  items dequeued in the current or most recent drain.

Function
REQ-017 FSM states SHALL be IDLE, CHECK, SETTLE and FLUSH.
REQ-018 IDLE: when start=1, latch remaining=n_req, clear n_done and underflow, and go to CHECK; start in any other state SHALL be ignored.
REQ-019 CHECK, dequeue case: if (n_req=0 or remaining>0), pq_busy=0, pq_empty=0 and the buffer is not full:
- assert pq_deq;
- write pq_kvo into the buffer in the same cycle;
- increment n_done; decrement remaining if nonzero;
- go to SETTLE.
REQ-020 CHECK, finish cases:
- n_req>0 and remaining=0: go to FLUSH.
- pq_busy=0 and pq_empty=1: go to FLUSH; set underflow when n_req>0.
- otherwise: stay in CHECK.
REQ-021 SETTLE SHALL last exactly one cycle with pq_deq=0 and then go to CHECK; this gives the queue time to raise pq_busy.
REQ-022 pq_deq SHALL never assert in two consecutive cycles, and SHALL never assert while pq_busy=1 or pq_empty=1.
REQ-023 FLUSH: when the buffer is empty, pulse done for one cycle and go to IDLE.
REQ-024 Buffer behaviour:
- FIFO order; out_valid = (count != 0); out_kv = head entry.
- An item is popped on out_valid && out_ready.
- A simultaneous push and pop when full SHALL NOT be allowed; the push waits.
- A simultaneous push and pop when count>0 SHALL leave count unchanged.
REQ-025 Latency: an item dequeued in cycle t SHALL appear on out_kv with out_valid=1 in cycle t+1.
REQ-026 Counters SHALL saturate at PQ_CAPACITY and SHALL NOT wrap.
REQ-027 out_kv SHALL hold its value while out_valid=1 and out_ready=0.

Reset
REQ-028 On rst=1 at a clock edge the block SHALL enter IDLE, whether or not a drain is in progress.
REQ-029 On that edge it SHALL set count=0, remaining=0 and n_done=0.
REQ-030 On that edge it SHALL drive pq_deq, out_valid, busy, done and underflow to 0, and out_kv to {KEY0,VAL0}.
REQ-031 A reset in mid-drain SHALL NOT issue any further pq_deq.

Structure
REQ-032 kv_t, KEY_WIDTH, VAL_WIDTH, PQ_CAPACITY, KEY0 and VAL0 SHALL come from pq_pkg.
REQ-033 PQ_CNT_W = $clog2(PQ_CAPACITY+1) SHALL be added to pq_pkg.
REQ-034 The output buffer SHALL be the sub-module kv_fifo, parameterised by depth, with synchronous reset.
REQ-035 The FSM state type SHALL be local to pq_drain.

Verification
REQ-036 Drain all, out_ready held at 1:
- stimulus: queue holds keys 5, 2, 9, 7; start with n_req=0;
- response: out_kv keys 2, 5, 7, 9; done pulses; n_done=4; underflow=0.
REQ-037 Partial drain:
- stimulus: queue holds 4 items; start with n_req=2;
- response: keys 1st and 2nd smallest are emitted; n_done=2; the queue still holds 2 items; underflow=0.
REQ-038 Underflow:
- stimulus: queue holds 3 items; start with n_req=5;
- response: 3 items emitted; underflow=1; done pulses; n_done=3.
REQ-039 Backpressure:
- stimulus: out_ready=0 for 20 cycles with BUF_DEPTH=2 and 6 items queued;
- response: exactly 2 pq_deq pulses; out_kv stable; after out_ready=1, all 6 items emitted in order.
REQ-040 Reset mid-drain:
- stimulus: rst asserted after the 2nd pq_deq of a 6-item drain;
- response: next cycle busy=0, out_valid=0, n_done=0; no further pq_deq.
REQ-041 Slow queue:
- stimulus: pq_busy held high 4 cycles after each dequeue;
- response: no pq_deq while busy; no back-to-back pq_deq; order preserved.
